// File: rtl/sha_2_pkg.sv
`default_nettype none
// ============================================================================
// Package : sha_2_pkg
// Brief   : SHA-2 round constants, initial hash values, width-generic sigma /
//           ch / maj helpers and the round engine state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package sha_2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic [31:0] K256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [31:0] H256_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [63:0] H512_INIT [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Words travel in a 64-bit carrier; for SHA-256 only bits [31:0] are meaningful.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n, input logic w64);
        logic [31:0] lo;
        lo = (x[31:0] >> n) | (x[31:0] << (32 - n));
        return w64 ? ((x >> n) | (x << (64 - n))) : {32'h0, lo};
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int unsigned n, input logic w64);
        return w64 ? (x >> n) : {32'h0, x[31:0] >> n};
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x, input logic w64);
        return w64 ? (rotr(x, 28, w64) ^ rotr(x, 34, w64) ^ rotr(x, 39, w64))
                   : (rotr(x, 2, w64)  ^ rotr(x, 13, w64) ^ rotr(x, 22, w64));
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x, input logic w64);
        return w64 ? (rotr(x, 14, w64) ^ rotr(x, 18, w64) ^ rotr(x, 41, w64))
                   : (rotr(x, 6, w64)  ^ rotr(x, 11, w64) ^ rotr(x, 25, w64));
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input logic w64);
        return w64 ? (rotr(x, 1, w64) ^ rotr(x, 8, w64)  ^ shr(x, 7, w64))
                   : (rotr(x, 7, w64) ^ rotr(x, 18, w64) ^ shr(x, 3, w64));
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input logic w64);
        return w64 ? (rotr(x, 19, w64) ^ rotr(x, 61, w64) ^ shr(x, 6, w64))
                   : (rotr(x, 17, w64) ^ rotr(x, 19, w64) ^ shr(x, 10, w64));
    endfunction

    function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [63:0] k_const(input logic [6:0] t, input logic w64);
        return w64 ? K512[t] : {32'h0, K256[t[5:0]]};
    endfunction

    function automatic logic [63:0] h_init(input logic [2:0] i, input logic w64);
        return w64 ? H512_INIT[i] : {32'h0, H256_INIT[i]};
    endfunction

    function automatic logic [31:0] bsig0_32(input logic [31:0] x);
        return 32'(bsig0({32'h0, x}, 1'b0));
    endfunction

    function automatic logic [31:0] bsig1_32(input logic [31:0] x);
        return 32'(bsig1({32'h0, x}, 1'b0));
    endfunction

    function automatic logic [31:0] ssig0_32(input logic [31:0] x);
        return 32'(ssig0({32'h0, x}, 1'b0));
    endfunction

    function automatic logic [31:0] ssig1_32(input logic [31:0] x);
        return 32'(ssig1({32'h0, x}, 1'b0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_2_round_engine_if.sv
`default_nettype none
// ============================================================================
// Interface : sha_2_round_engine_if
// Brief     : Block-in / digest-out valid-ready bundle of the round engine.
// Rev       : 1.0 - initial release
// ============================================================================
interface sha_2_round_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [16*DATA_WIDTH-1:0] in_block;
    logic                     in_first;
    logic                     in_last;
    logic                     in_valid;
    logic                     in_ready;
    logic [8*DATA_WIDTH-1:0]  out_digest;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_block, in_first, in_last, in_valid, out_ready,
        input  in_ready, out_digest, out_valid
    );

    modport slave (
        input  in_block, in_first, in_last, in_valid, out_ready,
        output in_ready, out_digest, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sha_2_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module : sha_2_msg_schedule
// Brief  : 16-word sliding window producing W_t, one word per advance.
// Rev    : 1.0 - initial release
// ============================================================================
module sha_2_msg_schedule
    import sha_2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_load,
    input  wire logic                     i_advance,
    input  wire logic [16*DATA_WIDTH-1:0] i_block,
    output logic      [DATA_WIDTH-1:0]    o_w
);

    localparam logic c_is64 = (DATA_WIDTH == 64);

    // r_win[k] holds W_(t+k) while round t is being computed.
    logic [DATA_WIDTH-1:0] r_win [0:15];
    logic [DATA_WIDTH-1:0] w_s0;
    logic [DATA_WIDTH-1:0] w_s1;
    logic [DATA_WIDTH-1:0] w_next;

    assign w_s0   = DATA_WIDTH'(ssig0(64'(r_win[1]), c_is64));
    assign w_s1   = DATA_WIDTH'(ssig1(64'(r_win[14]), c_is64));
    assign w_next = w_s1 + r_win[9] + w_s0 + r_win[0];
    assign o_w    = r_win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 16; j++) begin
                r_win[j] <= '0;
            end
        end else if (i_load) begin
            for (int j = 0; j < 16; j++) begin
                r_win[j] <= i_block[(16-j)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end else if (i_advance) begin
            for (int j = 0; j < 15; j++) begin
                r_win[j] <= r_win[j+1];
            end
            r_win[15] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha_2_round_engine.sv
`default_nettype none
// ============================================================================
// Module : sha_2_round_engine
// Brief  : Iterative SHA-256 / SHA-512 compression, one round per clock,
//          hash chained across the blocks of a message.
// Rev    : 1.0 - initial release
// ============================================================================
module sha_2_round_engine
    import sha_2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sha_2_round_engine_if.slave bus
);

    localparam int   ROUNDS = (DATA_WIDTH == 64) ? 80 : 64;
    localparam logic c_is64 = (DATA_WIDTH == 64);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "sha_2_round_engine: DATA_WIDTH must be 32 or 64");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [6:0]              r_round;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_work  [0:7];
    logic [DATA_WIDTH-1:0]   r_h     [0:7];
    logic [DATA_WIDTH-1:0]   w_h_sum [0:7];
    logic [8*DATA_WIDTH-1:0] r_out_digest;
    logic                    r_out_valid;

    logic w_accept;
    logic w_advance;
    logic w_final;
    logic w_in_ready;

    logic [DATA_WIDTH-1:0] w_w;
    logic [DATA_WIDTH-1:0] w_k;
    logic [DATA_WIDTH-1:0] w_bs0;
    logic [DATA_WIDTH-1:0] w_bs1;
    logic [DATA_WIDTH-1:0] w_ch;
    logic [DATA_WIDTH-1:0] w_maj;
    logic [DATA_WIDTH-1:0] w_t1;
    logic [DATA_WIDTH-1:0] w_t2;

    sha_2_msg_schedule #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sched (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_advance (w_advance),
        .i_block   (bus.in_block),
        .o_w       (w_w)
    );

    assign w_k   = DATA_WIDTH'(k_const(r_round, c_is64));
    assign w_bs0 = DATA_WIDTH'(bsig0(64'(r_work[0]), c_is64));
    assign w_bs1 = DATA_WIDTH'(bsig1(64'(r_work[4]), c_is64));
    assign w_ch  = DATA_WIDTH'(ch(64'(r_work[4]), 64'(r_work[5]), 64'(r_work[6])));
    assign w_maj = DATA_WIDTH'(maj(64'(r_work[0]), 64'(r_work[1]), 64'(r_work[2])));
    assign w_t1  = r_work[7] + w_bs1 + w_ch + w_k + w_w;
    assign w_t2  = w_bs0 + w_maj;

    for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
        assign w_h_sum[gi] = r_h[gi] + r_work[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_final     = 1'b0;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_advance = 1'b1;
                if (r_round == 7'(ROUNDS - 1)) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_final     = 1'b1;
                w_state_nxt = r_last ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Loading H with init on a first block makes the FINAL add uniform for
    // both first and chained blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round      <= '0;
            r_last       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_digest <= '0;
            for (int i = 0; i < 8; i++) begin
                r_work[i] <= '0;
                r_h[i]    <= DATA_WIDTH'(h_init(3'(i), c_is64));
            end
        end else begin
            if (w_accept) begin
                r_round <= '0;
                r_last  <= bus.in_last;
                for (int i = 0; i < 8; i++) begin
                    if (bus.in_first) begin
                        r_h[i]    <= DATA_WIDTH'(h_init(3'(i), c_is64));
                        r_work[i] <= DATA_WIDTH'(h_init(3'(i), c_is64));
                    end else begin
                        r_work[i] <= r_h[i];
                    end
                end
            end
            if (w_advance) begin
                r_round   <= r_round + 7'd1;
                r_work[0] <= w_t1 + w_t2;
                r_work[1] <= r_work[0];
                r_work[2] <= r_work[1];
                r_work[3] <= r_work[2];
                r_work[4] <= r_work[3] + w_t1;
                r_work[5] <= r_work[4];
                r_work[6] <= r_work[5];
                r_work[7] <= r_work[6];
            end
            if (w_final) begin
                for (int i = 0; i < 8; i++) begin
                    r_h[i] <= w_h_sum[i];
                end
                if (r_last) begin
                    r_out_valid <= 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        r_out_digest[(8-i)*DATA_WIDTH-1 -: DATA_WIDTH] <= w_h_sum[i];
                    end
                end
            end
            if (r_state == ST_OUT && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_digest = r_out_digest;

endmodule
`default_nettype wire

// File: tb/tb_sha_2_round_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_sha_2_round_engine
// Brief  : Directed known-answer bench for the SHA-256 and SHA-512 engines.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sha_2_round_engine;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sha_2_round_engine_if #(.DATA_WIDTH(32)) b32 ();
    sha_2_round_engine_if #(.DATA_WIDTH(64)) b64 ();

    sha_2_round_engine #(.DATA_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    sha_2_round_engine #(.DATA_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    localparam logic [511:0] c_blk_abc256 = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [1023:0] c_blk_abc512 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
    localparam logic [511:0] c_blk_two1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_blk_two2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] c_dig_abc256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] c_dig_two256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] c_dig_abc512 = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

    // One handshake on the 32-bit engine; caller ensures it is idle.
    task automatic send32(input logic [511:0] blk, input logic first, input logic last);
        b32.in_block = blk;
        b32.in_first = first;
        b32.in_last  = last;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready32: got %b want 1", b32.in_ready); end
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid32: got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.out_digest !== 256'h0) begin n_bad++; $display("FAIL rst_digest32: got %h want 0", b32.out_digest); end
        n_cmp++; if (b64.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready64: got %b want 1", b64.in_ready); end
        n_cmp++; if (b64.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid64: got %b want 0", b64.out_valid); end
        n_cmp++; if (b64.out_digest !== 512'h0) begin n_bad++; $display("FAIL rst_digest64: got %h want 0", b64.out_digest); end
    endtask

    task automatic test_sha256_abc();
        int n;
        send32(c_blk_abc256, 1'b1, 1'b1);
        n = 0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n + 1 != 66) begin n_bad++; $display("FAIL abc256_latency: got %0d want 66", n + 1); end
        n_cmp++; if (b32.out_digest !== c_dig_abc256) begin n_bad++; $display("FAIL abc256_digest: got %h want %h", b32.out_digest, c_dig_abc256); end
        @(posedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL abc256_valid_drop: got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL abc256_idle: got %b want 1", b32.in_ready); end
    endtask

    task automatic test_sha512_abc();
        int n;
        b64.in_block = c_blk_abc512;
        b64.in_first = 1'b1;
        b64.in_last  = 1'b1;
        b64.in_valid = 1'b1;
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        n = 0;
        while (b64.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n + 1 != 82) begin n_bad++; $display("FAIL abc512_latency: got %0d want 82", n + 1); end
        n_cmp++; if (b64.out_digest !== c_dig_abc512) begin n_bad++; $display("FAIL abc512_digest: got %h want %h", b64.out_digest, c_dig_abc512); end
        @(posedge clk); #1;
        n_cmp++; if (b64.out_valid !== 1'b0) begin n_bad++; $display("FAIL abc512_valid_drop: got %b want 0", b64.out_valid); end
    endtask

    task automatic test_two_block();
        int   n;
        logic saw;
        send32(c_blk_two1, 1'b1, 1'b0);
        n = 0;
        saw = 1'b0;
        while (b32.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
            if (b32.out_valid === 1'b1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL two_blk1_no_out: got %b want 0", saw); end
        n_cmp++; if (n + 1 != 66) begin n_bad++; $display("FAIL two_blk1_idle_cycle: got %0d want 66", n + 1); end
        send32(c_blk_two2, 1'b0, 1'b1);
        n = 0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (b32.out_digest !== c_dig_two256) begin n_bad++; $display("FAIL two_digest: got %h want %h", b32.out_digest, c_dig_two256); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n;
        b32.out_ready = 1'b0;
        send32(c_blk_abc256, 1'b1, 1'b1);
        n = 0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 20; k++) begin
            n_cmp++; if (b32.out_digest !== c_dig_abc256) begin n_bad++; $display("FAIL bp_digest[%0d]: got %h want %h", k, b32.out_digest, c_dig_abc256); end
            n_cmp++; if (b32.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", k, b32.out_valid); end
            n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, b32.in_ready); end
            @(posedge clk); #1;
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", b32.in_ready); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw;
        send32(c_blk_two1, 1'b1, 1'b0);
        repeat (30) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", b32.in_ready); end
        n_cmp++; if (b32.out_digest !== 256'h0) begin n_bad++; $display("FAIL mid_rst_digest: got %h want 0", b32.out_digest); end
        saw = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (b32.out_valid === 1'b1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_out: got %b want 0", saw); end
        send32(c_blk_abc256, 1'b1, 1'b1);
        n = 0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (b32.out_digest !== c_dig_abc256) begin n_bad++; $display("FAIL mid_rst_abc: got %h want %h", b32.out_digest, c_dig_abc256); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_zero_after_reset();
        int n;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send32(c_blk_abc256, 1'b0, 1'b1);
        n = 0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (b32.out_digest !== c_dig_abc256) begin n_bad++; $display("FAIL first0_digest: got %h want %h", b32.out_digest, c_dig_abc256); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int   n;
        logic saw;
        send32(c_blk_abc256, 1'b1, 1'b1);
        n = 0;
        repeat (10) begin @(posedge clk); #1; n++; end
        b32.in_block = {16{32'hdeadbeef}};
        b32.in_first = 1'b0;
        b32.in_last  = 1'b1;
        b32.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready[%0d]: got %b want 0", k, b32.in_ready); end
            @(posedge clk); #1; n++;
        end
        b32.in_valid = 1'b0;
        while (b32.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n + 1 != 66) begin n_bad++; $display("FAIL busy_latency: got %0d want 66", n + 1); end
        n_cmp++; if (b32.out_digest !== c_dig_abc256) begin n_bad++; $display("FAIL busy_digest: got %h want %h", b32.out_digest, c_dig_abc256); end
        saw = 1'b0;
        for (int k = 0; k < 90; k++) begin
            @(posedge clk); #1;
            if (k > 0 && b32.out_valid === 1'b1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL busy_not_consumed: got %b want 0", saw); end
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_final_idle: got %b want 1", b32.in_ready); end
    endtask

    initial begin
        rst = 1'b1;
        b32.in_block = '0; b32.in_first = 1'b0; b32.in_last = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        b64.in_block = '0; b64.in_first = 1'b0; b64.in_last = 1'b0; b64.in_valid = 1'b0; b64.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_sha256_abc();
        test_sha512_abc();
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_first_zero_after_reset();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
